// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: pixel type, signed max helper and layer geometry.
// Used by the conv layers and the pooling stages.
package lenet_pkg;

  localparam int bitwidth      = 32;
  localparam int CONV2_OUT_DIM = 10;
  localparam int POOL2_OUT_DIM = 5;
  localparam int CONV2_CH      = 2;

  typedef logic signed [bitwidth-1:0] pixel_t;

  // Signed maximum; on a tie the first argument (the earlier pixel) is kept.
  function automatic pixel_t smax(pixel_t a, pixel_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row buffer of horizontal pair maxima for the 2x2 pooling window.
// Single write port and an asynchronous read port sharing one address (col>>1).
// Contents are never reset; every entry is written on an even row before it is read.
module pool_line_buffer
  import lenet_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  // Even-row pair maxima are captured here for use on the following odd row
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_layer_2_stream.sv
// 2x2 / stride-2 signed max-pool over a raster pixel stream (channels sequential).
// Even columns park in a pair register, odd columns fold into a horizontal max,
// even rows park that max in a line buffer, odd rows finish the window and load
// a single-entry output register with valid/ready handshake.
// Build option: define RELU_EN to clamp negative pooled results to zero.
module pool_layer_2_stream #(
  parameter int bitwidth = lenet_pkg::bitwidth,
  parameter int IN_DIM   = lenet_pkg::CONV2_OUT_DIM,
  parameter int CHANNELS = lenet_pkg::CONV2_CH,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bitwidth-1:0] out_data,
  output logic                out_last,
  output logic [CH_W-1:0]     out_ch
);

  import lenet_pkg::*;

  localparam int CNT_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int LB_DEPTH = (IN_DIM / 2 > 0) ? IN_DIM / 2 : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  if (IN_DIM % 2 != 0) begin : g_dim_check
    $error("pool_layer_2_stream: IN_DIM must be even");
  end

  if (bitwidth != $bits(pixel_t)) begin : g_width_check
    $error("pool_layer_2_stream: bitwidth must match lenet_pkg::pixel_t");
  end

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CH_W-1:0]  ch;
  pixel_t           pair;
  pixel_t           pix;
  pixel_t           pm;
  pixel_t           lb_rd;
  pixel_t           result;
  pixel_t           act;
  logic [LB_AW-1:0] lb_addr;
  logic             xfer;
  logic             col_last;
  logic             row_last;
  logic             ch_last;
  logic             lb_we;
  logic             res_valid;

  assign in_ready  = !out_valid | out_ready;
  assign xfer      = in_valid & in_ready;
  assign col_last  = (col == CNT_W'(IN_DIM - 1));
  assign row_last  = (row == CNT_W'(IN_DIM - 1));
  assign ch_last   = (ch == CH_W'(CHANNELS - 1));
  assign pix       = pixel_t'(in_data);
  assign pm        = smax(pair, pix);
  assign result    = smax(lb_rd, pm);
  assign lb_addr   = LB_AW'(col >> 1);
  assign lb_we     = xfer & col[0] & ~row[0];
  assign res_valid = xfer & col[0] & row[0];

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pm),
    .rdata (lb_rd)
  );

  // Optional fused activation applied to the finished window before registering
  always_comb begin
    act = result;
`ifdef RELU_EN
    if (result < 0) act = '0;
`endif
  end

  // Raster position counters: col fastest, then row, then channel; wrap starts a new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (xfer) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
          ch  <= ch_last ? '0 : ch + CH_W'(1);
        end else begin
          row <= row + CNT_W'(1);
        end
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  // Even-column pixel waits here for its odd-column partner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair <= '0;
    end else if (xfer && !col[0]) begin
      pair <= pix;
    end
  end

  // Single-entry output register; a new result may replace a word consumed on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (res_valid) begin
      out_valid <= 1'b1;
      out_data  <= act;
      out_ch    <= ch;
      out_last  <= ch_last & row_last & col_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_layer_2_stream.sv
// Self-checking bench for pool_layer_2_stream: directed frames, scoreboard queue,
// backpressure, back-to-back frames, and mid-frame reset. Honours RELU_EN.
module tb_pool_layer_2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [0:0]  out_ch;

  typedef struct {
    logic [31:0] data;
    logic        ch;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   img [2][10][10];
  int   checks   = 0;
  int   failures = 0;

  pool_layer_2_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Build a test frame: 0 single window, 1 all negative, 2 ramp
  task automatic fillFrame(input int kind);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 10; r++)
        for (int k = 0; k < 10; k++)
          case (kind)
            0:       img[c][r][k] = 0;
            1:       img[c][r][k] = (c == 0) ? -1 : -5;
            default: img[c][r][k] = 100 * c + 10 * r + k;
          endcase
    if (kind == 0) begin
      img[0][0][0] = 3;
      img[0][0][1] = -7;
      img[0][1][0] = 9;
      img[0][1][1] = 1;
    end
  endtask

  // Reference model: push expected results of windows whose last pixel index < limit
  task automatic pushExpected(input int limit);
    exp_t e;
    int   m;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          if (c * 100 + (2 * i + 1) * 10 + 2 * j + 1 < limit) begin
            m = img[c][2*i][2*j];
            if (img[c][2*i][2*j+1] > m)   m = img[c][2*i][2*j+1];
            if (img[c][2*i+1][2*j] > m)   m = img[c][2*i+1][2*j];
            if (img[c][2*i+1][2*j+1] > m) m = img[c][2*i+1][2*j+1];
`ifdef RELU_EN
            if (m < 0) m = 0;
`endif
            e.data = m;
            e.ch   = (c == 1);
            e.last = (c == 1 && i == 4 && j == 4);
            q.push_back(e);
          end
        end
  endtask

  // Stream nPix pixels from img (repeating frames); optionally stall the first output
  task automatic applyStimulus(input int nPix, input int stallCycles);
    int idx       = 0;
    int cycles    = 0;
    int stallLeft = stallCycles;
    bit stalling;
    bit accepted;
    while (idx < nPix && cycles < nPix * 4 + 100) begin
      in_valid  = 1'b1;
      in_data   = img[(idx / 100) % 2][(idx / 10) % 10][idx % 10];
      stalling  = (stallLeft > 0) && out_valid;
      out_ready = !stalling;
      @(negedge clk);
      accepted = in_ready;
      if (stalling) begin
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_hold_data", out_data, (q.size() > 0) ? q[0].data : 32'hDEADBEEF);
        stallLeft--;
      end
      @(posedge clk);
      #1;
      if (accepted) idx++;
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput("stream_complete", idx, nPix);
  endtask

  // Let the output register empty and confirm every expected result was seen
  task automatic waitDrain();
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("drain_queue_empty", q.size(), 0);
  endtask

  // Scoreboard side: compare each accepted output against the queue head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checkOutput("output_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_ch", 32'(out_ch), 32'(e.ch));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  // Watchdog so a stuck handshake cannot hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] scenario 1: single window");
    fillFrame(0);
    pushExpected(200);
    applyStimulus(200, 0);
    waitDrain();

    $display("[TB] scenario 2: all negative");
    fillFrame(1);
    pushExpected(200);
    applyStimulus(200, 0);
    waitDrain();

    $display("[TB] scenario 3: backpressure on first output");
    fillFrame(0);
    pushExpected(200);
    applyStimulus(200, 5);
    waitDrain();

    $display("[TB] scenario 4: two frames back-to-back");
    fillFrame(2);
    pushExpected(200);
    pushExpected(200);
    applyStimulus(400, 0);
    waitDrain();

    $display("[TB] scenario 5: ramp frame");
    fillFrame(2);
    pushExpected(200);
    applyStimulus(200, 0);
    waitDrain();

    $display("[TB] scenario 6a: reset drops a pending output");
    applyStimulus(12, 0);
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("pending_valid", 32'(out_valid), 32'd1);
    checkOutput("pending_data", out_data, 32'd11);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_drop_valid", 32'(out_valid), 32'd0);
    checkOutput("async_drop_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    $display("[TB] scenario 6: reset after 37 pixels then fresh ramp");
    pushExpected(37);
    applyStimulus(37, 0);
    checkOutput("partial_outputs_seen", q.size(), 0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushExpected(200);
    applyStimulus(200, 0);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
